// File: rtl/piso_shift_register.sv
// rtl/piso_shift_register.sv - 32-bit parallel-in serial-out shifter with valid/ready handshakes
// Define PISO_PARITY_EN to append an even-parity beat after the 32 data bits.
module piso_shift_register (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] d,
   input  logic        load_valid,
   output logic        load_ready,
   input  logic        sout_ready,
   output logic        sout,
   output logic        sout_n,
   output logic        sout_valid,
   output logic        done
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1
`ifdef PISO_PARITY_EN
      ,
      PARITY = 2'd2
`endif
   } state_t;

   state_t      state;
   logic [31:0] sreg;
   logic [5:0]  cnt;
   logic        sout_q;
   logic        done_q;
   logic        load_ready_q;
   logic        sout_valid_q;
`ifdef PISO_PARITY_EN
   logic        parity_q;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         sreg         <= 32'd0;
         cnt          <= 6'd0;
         sout_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
         sout_valid_q <= 1'b0;
`ifdef PISO_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (load_valid) begin
                  sreg         <= d;
                  cnt          <= 6'd0;
                  sout_q       <= d[0];
                  state        <= SHIFT;
                  load_ready_q <= 1'b0;
                  sout_valid_q <= 1'b1;
`ifdef PISO_PARITY_EN
                  parity_q     <= 1'b0;
`endif
               end
            end
            SHIFT: begin
               if (sout_ready) begin
                  sreg <= {1'b0, sreg[31:1]};
                  cnt  <= cnt + 6'd1;
`ifdef PISO_PARITY_EN
                  // Parity accumulates each bit as it leaves the register.
                  parity_q <= parity_q ^ sreg[0];
                  if (cnt == 6'd31) begin
                     state  <= PARITY;
                     sout_q <= parity_q ^ sreg[0];
                  end else begin
                     sout_q <= sreg[1];
                  end
`else
                  if (cnt == 6'd31) begin
                     state        <= IDLE;
                     done_q       <= 1'b1;
                     load_ready_q <= 1'b1;
                     sout_valid_q <= 1'b0;
                     sout_q       <= sreg[0];
                  end else begin
                     sout_q <= sreg[1];
                  end
`endif
               end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
               if (sout_ready) begin
                  state        <= IDLE;
                  done_q       <= 1'b1;
                  load_ready_q <= 1'b1;
                  sout_valid_q <= 1'b0;
               end
            end
`endif
            default: begin
               state        <= IDLE;
               load_ready_q <= 1'b1;
               sout_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = load_ready_q;
   assign sout_valid = sout_valid_q;
   assign sout       = sout_q;
   assign sout_n     = ~sout_q;
   assign done       = done_q;

endmodule

// File: tb/tb_piso_shift_register.sv
// tb/tb_piso_shift_register.sv - directed self-checking bench for piso_shift_register
// Honours PISO_PARITY_EN to expect the extra parity beat.
module tb_piso_shift_register;

`ifdef PISO_PARITY_EN
   localparam int BEATS  = 33;
   localparam int PERIOD = 34;
`else
   localparam int BEATS  = 32;
   localparam int PERIOD = 33;
`endif

   logic        clk;
   logic        reset;
   logic [31:0] d;
   logic        load_valid;
   logic        load_ready;
   logic        sout_ready;
   logic        sout;
   logic        sout_n;
   logic        sout_valid;
   logic        done;

   int n_cmp;
   int n_err;

   piso_shift_register dut (
      .clk        (clk),
      .reset      (reset),
      .d          (d),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .sout_ready (sout_ready),
      .sout       (sout),
      .sout_n     (sout_n),
      .sout_valid (sout_valid),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_word(input logic [31:0] w);
      d          = w;
      load_valid = 1'b1;
      step();
      load_valid = 1'b0;
   endtask

   task automatic rx_word(output logic [31:0] data, output logic par, output int nb);
      data = 32'd0;
      par  = 1'b0;
      nb   = 0;
      for (int g = 0; g < 200 && sout_valid; g++) begin
         if (sout_ready) begin
            if (nb < 32) data[nb] = sout;
            else         par      = sout;
            nb++;
         end
         step();
      end
      chk("rx_bounded", {31'd0, sout_valid}, 32'd0);
   endtask

   logic        exp_bits [32] = '{1,0,0,0,0,0,0,0, 1,1,1,1,0,0,0,0,
                                  1,0,1,0,0,1,0,1, 1,0,1,0,0,1,0,1};
   logic [31:0] rx;
   logic        par;
   int          nb;
   int          t_done [3];
   int          k;
   int          rc;

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      reset      = 1'b0;
      load_valid = 1'b1;
      d          = 32'h5555_AAAA;
      sout_ready = 1'b1;

      // Reset held with load_valid high
      step();
      step();
      chk("rst_sout",       {31'd0, sout},       32'd0);
      chk("rst_sout_n",     {31'd0, sout_n},     32'd1);
      chk("rst_sout_valid", {31'd0, sout_valid}, 32'd0);
      chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
      chk("rst_done",       {31'd0, done},       32'd0);
      reset      = 1'b1;
      load_valid = 1'b0;
      step();
      chk("post_rst_idle",  {31'd0, sout_valid}, 32'd0);

      // Single word, LSB first
      load_word(32'hA5A5_0F01);
      chk("w1_valid",      {31'd0, sout_valid}, 32'd1);
      chk("w1_load_ready", {31'd0, load_ready}, 32'd0);
      chk("w1_sout_n",     {31'd0, sout_n},     32'd0);
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("w1_bit%0d", i), {31'd0, sout}, {31'd0, exp_bits[i]});
         chk($sformatf("w1_nodone%0d", i), {31'd0, done}, 32'd0);
         step();
      end
`ifdef PISO_PARITY_EN
      chk("w1_par_valid", {31'd0, sout_valid}, 32'd1);
      chk("w1_par_bit",   {31'd0, sout},       32'd1);
      step();
`endif
      chk("w1_done",       {31'd0, done},       32'd1);
      chk("w1_idle_valid", {31'd0, sout_valid}, 32'd0);
      chk("w1_idle_ready", {31'd0, load_ready}, 32'd1);
      chk("w1_hold_sout",  {31'd0, sout},       32'd1);
      step();
      chk("w1_done_pulse", {31'd0, done},       32'd0);
      chk("w1_hold_sout2", {31'd0, sout},       32'd1);

      // Stall after beat 1
      load_word(32'h0000_0003);
      step();
      sout_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_sout%0d", i),  {31'd0, sout},       32'd1);
         chk($sformatf("stall_valid%0d", i), {31'd0, sout_valid}, 32'd1);
         step();
      end
      sout_ready = 1'b1;
      rx_word(rx, par, nb);
      chk("stall_beats", nb + 1, BEATS);
      chk("stall_data",  rx,     32'h0000_0001);
      chk("stall_done",  {31'd0, done}, 32'd1);
      step();

      // Load attempt mid-word is ignored
      load_word(32'h1234_5678);
      step();
      step();
      step();
      d          = 32'hFFFF_FFFF;
      load_valid = 1'b1;
      chk("ign_ready_a", {31'd0, load_ready}, 32'd0);
      step();
      load_valid = 1'b0;
      chk("ign_ready_b", {31'd0, load_ready}, 32'd0);
      rx_word(rx, par, nb);
      chk("ign_beats", nb, BEATS - 4);
      chk("ign_data",  rx, 32'h0123_4567);
`ifdef PISO_PARITY_EN
      chk("ign_par",   {31'd0, par}, 32'd1);
`endif
      chk("ign_done",  {31'd0, done}, 32'd1);
      step();

      // Reset aborts a word in flight
      load_word(32'hDEAD_BEEF);
      for (int i = 0; i < 10; i++) step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("abort_valid", {31'd0, sout_valid}, 32'd0);
      chk("abort_ready", {31'd0, load_ready}, 32'd1);
      chk("abort_sout",  {31'd0, sout},       32'd0);
      chk("abort_done",  {31'd0, done},       32'd0);
      step();
      chk("abort_done2", {31'd0, done},       32'd0);
      load_word(32'h0000_0001);
      rx_word(rx, par, nb);
      chk("after_abort_beats", nb, BEATS);
      chk("after_abort_data",  rx, 32'h0000_0001);
`ifdef PISO_PARITY_EN
      chk("after_abort_par",   {31'd0, par}, 32'd1);
`endif
      chk("after_abort_done",  {31'd0, done}, 32'd1);
      step();

      // Back-to-back words with load_valid held
      d          = 32'h0F0F_F0F0;
      load_valid = 1'b1;
      k          = 0;
      rc         = 0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (load_ready) rc++;
         if (done) begin
            t_done[k] = cyc;
            k++;
         end
         if (k == 3) begin
            load_valid = 1'b0;
            break;
         end
         step();
      end
      load_valid = 1'b0;
      chk("b2b_count", k, 3);
      if (k == 3) begin
         chk("b2b_gap1", t_done[1] - t_done[0], PERIOD);
         chk("b2b_gap2", t_done[2] - t_done[1], PERIOD);
      end
      chk("b2b_ready_cycles", rc, 4);
      step();
      chk("b2b_stop", {31'd0, sout_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
